brent_kung_pipe_adder: RTL and testbench

- Parametrised, pipelined successor to the 16-bit combinational Brent-Kung adder.
- Adds or subtracts two WIDTH-bit operands through a registered Brent-Kung prefix carry network.
- Uses a valid/ready handshake on input and output, and provides carry-out and signed-overflow flags.
- Sits in the datapath wherever a full-throughput adder with backpressure is needed.

---
 rtl/bk_pkg.sv | 24 ++
 rtl/bk_prefix_tree.sv | 57 +++++
 rtl/brent_kung_pipe_adder.sv | 114 +++++++++++
 tb/tb_brent_kung_pipe_adder.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bk_pkg.sv
// Shared constants and elaboration helpers for the Brent-Kung adder family.
package bk_pkg;

    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;

    // Ceiling log2 for elaboration-time sizing of the prefix tree.
    function automatic int bk_clog2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Legal operand widths: a power of two from 4 to 64.
    function automatic bit bk_width_ok(input int width);
        return (width >= 4) && (width <= 64) && ((width & (width - 1)) == 0);
    endfunction

endpackage

// File: rtl/bk_prefix_tree.sv
// Combinational Brent-Kung carry network: generate/propagate in, all carries out.
// The carry-in is folded into bit 0 generate, so c[i+1] is the group generate of bits i..0.
module bk_prefix_tree
    import bk_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] g,
    input  logic [WIDTH-1:0] p,
    input  logic             c0,
    output logic [WIDTH:0]   c
);

    localparam int LEVELS = bk_clog2(WIDTH);

    // Level 0 is the raw input; up-sweep fills levels 1..LEVELS, down-sweep the rest.
    logic [WIDTH-1:0] g_lvl [0:2*LEVELS-1];
    logic [WIDTH-1:0] p_lvl [0:2*LEVELS-2];

    assign g_lvl[0] = {g[WIDTH-1:1], g[0] | (p[0] & c0)};
    assign p_lvl[0] = p;

    // Up-sweep: node i at level l combines with the span ending 2^l bits below it.
    for (genvar l = 0; l < LEVELS; l++) begin : g_up
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if ((i % (2 << l)) == ((2 << l) - 1)) begin : g_node
                assign g_lvl[l+1][i] = g_lvl[l][i] | (p_lvl[l][i] & g_lvl[l][i - (1 << l)]);
                assign p_lvl[l+1][i] = p_lvl[l][i] & p_lvl[l][i - (1 << l)];
            end else begin : g_pass
                assign g_lvl[l+1][i] = g_lvl[l][i];
                assign p_lvl[l+1][i] = p_lvl[l][i];
            end
        end
    end

    // Down-sweep: fill the remaining positions from the nearest completed prefix below.
    for (genvar d = 0; d < LEVELS - 1; d++) begin : g_down
        localparam int S   = LEVELS - 2 - d;
        localparam int SRC = LEVELS + d;
        for (genvar i = 0; i < WIDTH; i++) begin : g_bit
            if ((i >= ((3 << S) - 1)) && ((i % (2 << S)) == ((1 << S) - 1))) begin : g_node
                assign g_lvl[SRC+1][i] = g_lvl[SRC][i] | (p_lvl[SRC][i] & g_lvl[SRC][i - (1 << S)]);
                if (d < LEVELS - 2) begin : g_pnode
                    assign p_lvl[SRC+1][i] = p_lvl[SRC][i] & p_lvl[SRC][i - (1 << S)];
                end
            end else begin : g_pass
                assign g_lvl[SRC+1][i] = g_lvl[SRC][i];
                if (d < LEVELS - 2) begin : g_ppass
                    assign p_lvl[SRC+1][i] = p_lvl[SRC][i];
                end
            end
        end
    end

    assign c = {g_lvl[2*LEVELS-1], c0};

endmodule

// File: rtl/brent_kung_pipe_adder.sv
// Three-stage pipelined Brent-Kung adder/subtractor with valid/ready flow control.
// The whole pipeline freezes only when the output register holds a result nobody takes.
module brent_kung_pipe_adder
    import bk_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int LATENCY = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] data_1,
    input  logic [WIDTH-1:0] data_2,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] res,
    output logic             cout,
    output logic             ovf
);

    if (!bk_width_ok(WIDTH)) begin : g_bad_width
        $error("brent_kung_pipe_adder: WIDTH must be a power of 2 in 4..64");
    end
    if (LATENCY != 3) begin : g_bad_latency
        $error("brent_kung_pipe_adder: LATENCY is fixed at 3");
    end

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] g;
        logic [WIDTH-1:0] p;
        logic             c0;
    } bk_stage_t;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] p;
        logic [WIDTH:0]   c;
    } carry_stage_t;

    typedef struct packed {
        logic             valid;
        logic [WIDTH-1:0] res;
        logic             cout;
        logic             ovf;
    } out_stage_t;

    bk_stage_t        s1_d, s1_q;
    carry_stage_t     s2_d, s2_q;
    out_stage_t       s3_d, s3_q;
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] b_mod;
    logic             stall;

    assign stall     = s3_q.valid & ~out_ready;
    assign in_ready  = ~stall;
    assign out_valid = s3_q.valid;
    assign res       = s3_q.res;
    assign cout      = s3_q.cout;
    assign ovf       = s3_q.ovf;

    // Operand conditioning: invert B and force carry-in for subtraction.
    always_comb begin
        b_mod    = data_2 ^ {WIDTH{sub}};
        s1_d       = '0;
        s1_d.valid = in_valid;
        s1_d.g     = data_1 & b_mod;
        s1_d.p     = data_1 ^ b_mod;
        s1_d.c0    = (sub == MODE_SUB) ? 1'b1 : cin;
    end

    bk_prefix_tree #(
        .WIDTH (WIDTH)
    ) u_prefix_tree (
        .g  (s1_q.g),
        .p  (s1_q.p),
        .c0 (s1_q.c0),
        .c  (carry)
    );

    // Carry stage keeps propagate alongside the carries for the final sum.
    always_comb begin
        s2_d       = '0;
        s2_d.valid = s1_q.valid;
        s2_d.p     = s1_q.p;
        s2_d.c     = carry;
    end

    // Output stage: sum bits, carry-out and signed overflow from the carry vector.
    always_comb begin
        s3_d       = '0;
        s3_d.valid = s2_q.valid;
        s3_d.res   = s2_q.p ^ s2_q.c[WIDTH-1:0];
        s3_d.cout  = s2_q.c[WIDTH];
        s3_d.ovf   = s2_q.c[WIDTH] ^ s2_q.c[WIDTH-1];
    end

    // All stages advance together, bubbles included, unless the output is stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_q <= '0;
            s2_q <= '0;
            s3_q <= '0;
        end else if (!stall) begin
            s1_q <= s1_d;
            s2_q <= s2_d;
            s3_q <= s3_d;
        end
    end

endmodule

// File: tb/tb_brent_kung_pipe_adder.sv
// Self-checking bench for brent_kung_pipe_adder (WIDTH=16): directed cases, random traffic,
// backpressure and asynchronous reset, scored against an arithmetic reference model.
module tb_brent_kung_pipe_adder;
    import bk_pkg::*;

    localparam int W = 16;
    localparam longint MAX_POS = (longint'(1) << (W - 1)) - 1;
    localparam longint MIN_NEG = -(longint'(1) << (W - 1));

    logic         clk       = 1'b0;
    logic         rst       = 1'b0;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] data_1    = '0;
    logic [W-1:0] data_2    = '0;
    logic         cin       = 1'b0;
    logic         sub       = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] res;
    logic         cout;
    logic         ovf;

    typedef struct {
        logic [W-1:0] res;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t         exp_q[$];
    logic [W-1:0] log_res[$];
    logic         log_cout[$];
    logic         log_ovf[$];

    int           checks = 0;
    int           failures = 0;
    int           adv_cnt = 0;
    logic         prev_stall = 1'b0;
    logic [W-1:0] prev_res;
    logic         prev_cout;
    logic         prev_ovf;
    logic         rand_done;
    logic [W-1:0] rand_a;
    logic [W-1:0] rand_b;

    brent_kung_pipe_adder #(
        .WIDTH   (W),
        .LATENCY (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .data_1    (data_1),
        .data_2    (data_2),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .cout      (cout),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Reference: plain unsigned and signed arithmetic on the operands.
    function automatic exp_t refModel(input logic [W-1:0] a, input logic [W-1:0] b,
                                      input logic c, input logic s, input int acc);
        exp_t   e;
        longint ua, ub, sa, sb, total, signed_total;
        ua = 0;
        ub = 0;
        ua[W-1:0] = a;
        ub[W-1:0] = b;
        sa = a[W-1] ? ua - (longint'(1) << W) : ua;
        sb = b[W-1] ? ub - (longint'(1) << W) : ub;
        if (s == MODE_SUB) begin
            total        = ua - ub;
            e.cout       = (ua >= ub);
            signed_total = sa - sb;
        end else begin
            total        = ua + ub + longint'(c);
            e.cout       = (total >= (longint'(1) << W));
            signed_total = sa + sb + longint'(c);
        end
        e.res = total[W-1:0];
        e.ovf = (signed_total > MAX_POS) || (signed_total < MIN_NEG);
        e.acc = acc;
        return e;
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    // Called just after a rising edge; holds in_valid until the operands are accepted.
    task automatic applyStimulus(input logic [W-1:0] a, input logic [W-1:0] b, input logic c, input logic s);
        int waited;
        data_1   = a;
        data_2   = b;
        cin      = c;
        sub      = s;
        in_valid = 1'b1;
        waited   = 0;
        @(negedge clk);
        while (!in_ready && waited < 100) begin
            waited++;
            @(negedge clk);
        end
        checkOutput("accept_timeout", waited < 100, 1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drainPipe();
        int waited;
        waited = 0;
        while (exp_q.size() != 0 && waited < 200) begin
            @(posedge clk);
            #1;
            waited++;
        end
        checkOutput("drain_timeout", exp_q.size(), 0);
    endtask

    task automatic checkLast(input string tag, input logic [W-1:0] r, input logic co, input logic ov);
        checkOutput("log_nonempty", log_res.size() > 0, 1);
        if (log_res.size() > 0) begin
            checkOutput({tag, "_res"}, log_res[$], r);
            checkOutput({tag, "_cout"}, log_cout[$], co);
            checkOutput({tag, "_ovf"}, log_ovf[$], ov);
        end
    endtask

    // Scoreboard: handshakes, latency, stability under stall and result values.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            prev_stall = 1'b0;
            checkOutput("reset_out_valid", out_valid, 0);
            checkOutput("reset_res", res, 0);
            checkOutput("reset_cout", cout, 0);
            checkOutput("reset_ovf", ovf, 0);
        end else begin
            checkOutput("in_ready", in_ready, !(out_valid && !out_ready));
            if (out_valid) begin
                checkOutput("unexpected_out_valid", exp_q.size() != 0, 1);
                if (exp_q.size() != 0) begin
                    if (prev_stall) begin
                        checkOutput("held_res", res, prev_res);
                        checkOutput("held_cout", cout, prev_cout);
                        checkOutput("held_ovf", ovf, prev_ovf);
                    end else begin
                        checkOutput("latency", adv_cnt, exp_q[0].acc + 2);
                    end
                    if (out_ready) begin
                        checkOutput("res", res, exp_q[0].res);
                        checkOutput("cout", cout, exp_q[0].cout);
                        checkOutput("ovf", ovf, exp_q[0].ovf);
                        log_res.push_back(res);
                        log_cout.push_back(cout);
                        log_ovf.push_back(ovf);
                        void'(exp_q.pop_front());
                    end
                end
            end else if (exp_q.size() != 0) begin
                checkOutput("result_overdue", adv_cnt < exp_q[0].acc + 2, 1);
            end
            prev_stall = out_valid && !out_ready;
            prev_res   = res;
            prev_cout  = cout;
            prev_ovf   = ovf;
            if (in_valid && in_ready) begin
                exp_q.push_back(refModel(data_1, data_2, cin, sub, adv_cnt + 1));
            end
            if (!(out_valid && !out_ready)) begin
                adv_cnt++;
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog observed=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int base;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("in_ready_after_reset", in_ready, 1);
        checkOutput("out_valid_after_reset", out_valid, 0);

        $display("[TB] directed back-to-back adds");
        base = log_res.size();
        applyStimulus(16'd14, 16'd1, 1'b0, MODE_ADD);
        applyStimulus(16'd15, 16'd1, 1'b0, MODE_ADD);
        applyStimulus(16'd16, 16'd1, 1'b0, MODE_ADD);
        applyStimulus(16'd17, 16'd5, 1'b0, MODE_ADD);
        applyStimulus(16'd2,  16'd5, 1'b0, MODE_ADD);
        drainPipe();
        checkOutput("directed_count", log_res.size() - base, 5);
        if (log_res.size() - base == 5) begin
            checkOutput("add_14_1", log_res[base],     16'd15);
            checkOutput("add_15_1", log_res[base + 1], 16'd16);
            checkOutput("add_16_1", log_res[base + 2], 16'd17);
            checkOutput("add_17_5", log_res[base + 3], 16'd22);
            checkOutput("add_2_5",  log_res[base + 4], 16'd7);
        end

        $display("[TB] arithmetic boundaries");
        applyStimulus(16'hFFFF, 16'h0001, 1'b0, MODE_ADD); drainPipe();
        checkLast("wrap", 16'h0000, 1'b1, 1'b0);
        applyStimulus(16'h7FFF, 16'h0001, 1'b0, MODE_ADD); drainPipe();
        checkLast("pos_ovf", 16'h8000, 1'b0, 1'b1);
        applyStimulus(16'd5, 16'd2, 1'b0, MODE_SUB); drainPipe();
        checkLast("sub_5_2", 16'd3, 1'b1, 1'b0);
        applyStimulus(16'd2, 16'd5, 1'b0, MODE_SUB); drainPipe();
        checkLast("sub_2_5", 16'hFFFD, 1'b0, 1'b0);
        applyStimulus(16'h8000, 16'd1, 1'b0, MODE_SUB); drainPipe();
        checkLast("neg_ovf", 16'h7FFF, 1'b1, 1'b1);
        applyStimulus(16'd7, 16'd7, 1'b1, MODE_SUB); drainPipe();
        checkLast("sub_cin_ignored", 16'd0, 1'b1, 1'b0);

        $display("[TB] backpressure stream");
        base = log_res.size();
        fork
            begin
                for (int i = 0; i < 10; i++) begin
                    applyStimulus(W'(100 + i), W'(3 * i), i[0], MODE_ADD);
                end
            end
            begin
                repeat (6) @(posedge clk);
                #1;
                out_ready = 1'b0;
                #1;
                checkOutput("stall_out_valid", out_valid, 1);
                checkOutput("stall_in_ready", in_ready, 0);
                repeat (5) @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drainPipe();
        checkOutput("stream_count", log_res.size() - base, 10);
        if (log_res.size() - base == 10) begin
            for (int i = 0; i < 10; i++) begin
                checkOutput("stream_order", log_res[base + i], 64'(100 + 4 * i + (i % 2)));
            end
        end

        $display("[TB] random traffic");
        rand_done = 1'b0;
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    case ($urandom_range(0, 4))
                        0:       rand_a = 16'hFFFF;
                        1:       rand_a = 16'h8000;
                        2:       rand_a = 16'h7FFF;
                        default: rand_a = W'($urandom);
                    endcase
                    rand_b = ($urandom_range(0, 3) == 0) ? rand_a : W'($urandom);
                    applyStimulus(rand_a, rand_b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                    repeat ($urandom_range(0, 2)) begin
                        @(posedge clk);
                        #1;
                    end
                end
                rand_done = 1'b1;
            end
            begin
                while (!rand_done) begin
                    @(posedge clk);
                    #1;
                    out_ready = ($urandom_range(0, 3) != 0);
                end
                out_ready = 1'b1;
            end
        join
        out_ready = 1'b1;
        drainPipe();

        $display("[TB] asynchronous reset with work in flight");
        applyStimulus(16'd3, 16'd4, 1'b0, MODE_ADD);
        applyStimulus(16'd5, 16'd6, 1'b0, MODE_ADD);
        applyStimulus(16'd7, 16'd8, 1'b0, MODE_ADD);
        checkOutput("pre_reset_out_valid", out_valid, 1);
        #2;
        rst = 1'b1;
        #1;
        checkOutput("async_reset_out_valid", out_valid, 0);
        checkOutput("async_reset_res", res, 0);
        repeat (2) @(posedge clk);
        #3;
        rst = 1'b0;
        repeat (6) begin
            @(posedge clk);
            #1;
            checkOutput("no_stale_after_reset", out_valid, 0);
        end
        applyStimulus(16'd1, 16'd1, 1'b0, MODE_ADD);
        drainPipe();
        checkLast("post_reset_1_1", 16'd2, 1'b0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
